// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared constants, state encoding and command-decode helpers for the bus
// transfer sequencer.
package bus_xfer_ctrl_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [1:0] XFER_MOVE = 2'b00;
  localparam logic [1:0] XFER_LOAD = 2'b01;
  localparam logic [1:0] XFER_READ = 2'b10;
  localparam logic [1:0] XFER_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_XFER  = 2'b10,
    ST_DONE  = 2'b11
  } xfer_state_e;

  function automatic logic mode_uses_src(input logic [1:0] mode);
    return (mode == XFER_MOVE) || (mode == XFER_READ);
  endfunction

  function automatic logic mode_uses_dst(input logic [1:0] mode);
    return (mode == XFER_MOVE) || (mode == XFER_LOAD);
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_sel_decoder.sv
// Slot index to one-hot decoder; o_valid flags indices that name an existing
// slot, so out-of-range indices decode to all-zero.
module sel_decoder #(
  parameter int SEL_W    = 3,
  parameter int NUM_REGS = 8
) (
  input  logic [SEL_W-1:0]    i_sel,
  output logic [NUM_REGS-1:0] o_onehot,
  output logic                o_valid
);

  // one-hot expansion of the index
  always_comb begin
    o_onehot = {NUM_REGS{1'b0}};
    o_valid  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(i_sel) == i) begin
        o_onehot[i] = 1'b1;
        o_valid     = 1'b1;
      end else begin
        o_onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Transfer sequencer for the shared slot data bus: one command per handshake,
// four-cycle IDLE/SETUP/XFER/DONE walk with registered per-slot strobes.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int DW       = DATA_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    src_sel,
  input  logic [SEL_W-1:0]    dst_sel,
  input  logic [DW-1:0]       imm,
  output logic                ack,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DW-1:0]       rdata,
  output logic [NUM_REGS-1:0] cs,
  output logic [NUM_REGS-1:0] oe,
  output logic [NUM_REGS-1:0] en,
  inout  wire  [DW-1:0]       data_bus
);

  xfer_state_e         r_state;
  logic [NUM_REGS-1:0] r_dst_oh;
  logic [DW-1:0]       r_imm;
  logic                r_drive;
  logic                r_ack;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [DW-1:0]       r_rdata;
  logic [NUM_REGS-1:0] r_cs;
  logic [NUM_REGS-1:0] r_oe;
  logic [NUM_REGS-1:0] r_en;

  logic [NUM_REGS-1:0] w_src_oh;
  logic [NUM_REGS-1:0] w_dst_oh;
  logic                w_src_ok;
  logic                w_dst_ok;
  logic                w_uses_src;
  logic                w_uses_dst;
  logic                w_legal;

  sel_decoder #(
    .SEL_W    (SEL_W),
    .NUM_REGS (NUM_REGS)
  ) u_src_dec (
    .i_sel    (src_sel),
    .o_onehot (w_src_oh),
    .o_valid  (w_src_ok)
  );

  sel_decoder #(
    .SEL_W    (SEL_W),
    .NUM_REGS (NUM_REGS)
  ) u_dst_dec (
    .i_sel    (dst_sel),
    .o_onehot (w_dst_oh),
    .o_valid  (w_dst_ok)
  );

  // command legality: reserved mode, self-move and unused-slot indices are rejected
  always_comb begin
    w_uses_src = mode_uses_src(mode);
    w_uses_dst = mode_uses_dst(mode);
    if (mode == XFER_RSVD) begin
      w_legal = 1'b0;
    end else if ((mode == XFER_MOVE) && (src_sel == dst_sel)) begin
      w_legal = 1'b0;
    end else begin
      w_legal = (w_src_ok || !w_uses_src) && (w_dst_ok || !w_uses_dst);
    end
  end

  // sequencer FSM; strobes for the next state are set on the entering edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_dst_oh <= {NUM_REGS{1'b0}};
      r_imm    <= {DW{1'b0}};
      r_drive  <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= {DW{1'b0}};
      r_cs     <= {NUM_REGS{1'b0}};
      r_oe     <= {NUM_REGS{1'b0}};
      r_en     <= {NUM_REGS{1'b0}};
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req && w_legal) begin
            r_state  <= ST_SETUP;
            r_ack    <= 1'b1;
            r_busy   <= 1'b1;
            r_imm    <= imm;
            r_dst_oh <= w_uses_dst ? w_dst_oh : {NUM_REGS{1'b0}};
            r_cs     <= w_uses_src ? w_src_oh : {NUM_REGS{1'b0}};
            r_oe     <= w_uses_src ? w_src_oh : {NUM_REGS{1'b0}};
            r_drive  <= (mode == XFER_LOAD);
          end else if (req) begin
            r_err <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          // source keeps driving; destination (if any) joins for the latch cycle
          r_state <= ST_XFER;
          r_cs    <= r_cs | r_dst_oh;
          r_en    <= r_dst_oh;
        end
        ST_XFER: begin
          r_state <= ST_DONE;
          r_rdata <= data_bus;
          r_cs    <= {NUM_REGS{1'b0}};
          r_oe    <= {NUM_REGS{1'b0}};
          r_en    <= {NUM_REGS{1'b0}};
          r_drive <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_drive <= 1'b0;
          r_cs    <= {NUM_REGS{1'b0}};
          r_oe    <= {NUM_REGS{1'b0}};
          r_en    <= {NUM_REGS{1'b0}};
        end
      endcase
    end
  end

  assign data_bus = r_drive ? r_imm : {DW{1'bz}};

  assign ack   = r_ack;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign cs    = r_cs;
  assign oe    = r_oe;
  assign en    = r_en;

endmodule
